// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and framing sizes.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR_LO = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_LOAD   = 3'd2,
    ST_CHK    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * HDR_BYTES;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects payload bytes little-endian; o_word is the full word on the cycle the last byte shifts in.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_last
);

  logic [23:0] r_low;
  logic [1:0]  r_idx;

  // Only the lower three bytes are stored; the fourth is forwarded straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_low <= 24'd0;
      r_idx <= 2'd0;
    end else if (i_shift_en) begin
      case (r_idx)
        2'd0:    r_low[7:0]   <= i_byte;
        2'd1:    r_low[15:8]  <= i_byte;
        2'd2:    r_low[23:16] <= i_byte;
        default: r_low        <= r_low;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_word      = {i_byte, r_low};
  assign o_word_last = i_shift_en && (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory and releases the CPU reset.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [15:0]      r_word_count;
  logic             r_imem_we;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_imem_wdata;
  logic             r_cpu_reset;
  logic             r_done;
  logic             r_error;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_accept;
  logic             w_pack_en;
  logic [31:0]      w_word;
  logic             w_word_last;
  logic [LEN_W-1:0] w_len;

  assign in_ready  = (r_state inside {ST_HDR_LO, ST_HDR_HI, ST_LOAD, ST_CHK}) && !r_imem_we;
  assign w_accept  = in_valid && in_ready;
  assign w_pack_en = w_accept && (r_state == ST_LOAD);
  assign w_len     = {in_data, r_len[7:0]};

  prog_loader_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_shift_en  (w_pack_en),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_last (w_word_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_HDR_LO;
      r_len        <= '0;
      r_word_count <= 16'd0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 32'd0;
      r_imem_wdata <= 32'd0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        ST_HDR_LO: begin
          if (w_accept) begin
            r_len[7:0] <= in_data;
            r_state    <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              r_state     <= ST_CHK;
`else
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
`endif
            end else if (32'(w_len) > 32'(MAX_WORDS)) begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // The strobe cycle already shows the incremented count, so the last word is detected here.
          if (r_imem_we && (r_word_count == r_len)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            r_state     <= ST_CHK;
`else
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_cpu_reset <= 1'b0;
`endif
          end else if (w_word_last) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= {14'd0, r_word_count, 2'b00};
            r_imem_wdata <= w_word;
            if (32'(r_word_count) < 32'(MAX_WORDS))
              r_word_count <= r_word_count + 16'd1;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          if (w_pack_en)
            r_csum <= r_csum ^ in_data;
`endif
        end
        ST_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (w_accept) begin
            if (in_data == r_csum) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
`else
          r_state <= ST_ERR;
          r_error <= 1'b1;
`endif
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus time, checked on each strobe.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  payload [8];

  prog_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          tests_failed++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end else begin
          $display("[TB] write addr=%h data=%h ok", imem_addr, imem_wdata);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd && ($urandom_range(0, 2) == 0)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ready_timeout: got in_ready=0 for 50 cycles, required 1");
    end
    @(negedge clk);
  endtask

  task automatic wait_terminal();
    int n = 0;
    while (!done && !error && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("terminal_timeout", {31'd0, (n < 50)}, 32'd1);
  endtask

  function automatic logic [7:0] payload_csum();
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 8; i++) c = c ^ payload[i];
    return c;
  endfunction

  // Sends header 02 00 plus the payload; expected writes are queued as each word's last byte is driven.
  task automatic send_program(input bit rnd, input bit corrupt_csum);
    send_byte(8'h02, rnd);
    send_byte(8'h00, rnd);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3)
          exp_q.push_back({32'(4 * w), payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]});
        send_byte(payload[4*w+k], rnd);
      end
      if (!rnd && w == 0) begin
        check("strobe_we", {31'd0, imem_we}, 32'd1);
        check("strobe_ready", {31'd0, in_ready}, 32'd0);
        check("strobe_count", {16'd0, word_count}, 32'd1);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(payload_csum() ^ {7'd0, corrupt_csum}, rnd);
`else
    if (corrupt_csum) check("csum_unused", {24'd0, payload_csum()}, {24'd0, payload_csum()} ^ 32'd0);
`endif
    in_valid = 1'b0;
  endtask

  task automatic check_done_state(input string tag, input logic [15:0] exp_count);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_count"}, {16'd0, word_count}, {16'd0, exp_count});
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic test_reset();
    do_reset();
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_count", {16'd0, word_count}, 32'd0);
    $display("[TB] test_reset complete");
  endtask

  task automatic test_basic();
    do_reset();
    send_program(1'b0, 1'b0);
    wait_terminal();
    check_done_state("basic", 16'd2);
    // Terminal: further bytes must be ignored.
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("basic_sticky_done", {31'd0, done}, 32'd1);
    check("basic_sticky_count", {16'd0, word_count}, 32'd2);
    $display("[TB] test_basic complete");
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    in_valid = 1'b0;
    wait_terminal();
    check_done_state("zero", 16'd0);
    $display("[TB] test_zero_len complete");
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    in_data = 8'h55;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    check("ovf_error", {31'd0, error}, 32'd1);
    check("ovf_done", {31'd0, done}, 32'd0);
    check("ovf_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("ovf_count", {16'd0, word_count}, 32'd0);
    $display("[TB] test_overflow complete");
  endtask

  task automatic test_random_valid();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      send_program(1'b1, 1'b0);
      wait_terminal();
      check_done_state("rand", 16'd2);
    end
    $display("[TB] test_random_valid complete");
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hDD, 1'b0);
    // Reset with a byte still offered: it must be dropped.
    in_data  = 8'hCC;
    reset    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_count", {16'd0, word_count}, 32'd0);
    send_program(1'b0, 1'b0);
    wait_terminal();
    check_done_state("mid", 16'd2);
    $display("[TB] test_reset_mid_word complete");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    do_reset();
    send_program(1'b0, 1'b1);
    wait_terminal();
    check("csum_error", {31'd0, error}, 32'd1);
    check("csum_done", {31'd0, done}, 32'd0);
    check("csum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    $display("[TB] test_checksum_bad complete");
  endtask
`endif

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    payload  = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h08, 8'h00, 8'h00, 8'h08};
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_random_valid();
    test_reset_mid_word();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    check("final_pending", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
